pio_cmd_exec: RTL and testbench
===============================

PIO_CMD_EXEC -- requirements
Module: pio_cmd_exec

Interface
REQ-001 SHALL have parameter DrainOnError, default 1; when 1, unconsumed TX DWORDs of a failed write are popped and discarded.
REQ-002 SHALL have clk_i  input  1  clock.
REQ-003 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have enable_i  input  1  controller enable; new commands are fetched only while high.
REQ-005 SHALL have cmdrst_i, txrst_i, rxrst_i, resprst_i  input  1 each  queue soft resets.
REQ-006 SHALL have cmd_fifo_rvalid_i / cmd_fifo_rready_o / cmd_fifo_rdata_i  in/out/in  1/1/CmdFifoWidth (64)  command pop.
REQ-007 SHALL have tx_fifo_rvalid_i / tx_fifo_rready_o / tx_fifo_rdata_i  in/out/in  1/1/TxFifoWidth (32)  TX data pop.
REQ-008 SHALL have rx_fifo_wvalid_o / rx_fifo_wready_i / rx_fifo_wdata_o  out/in/out  1/1/RxFifoWidth (32)  RX data push.
REQ-009 SHALL have resp_fifo_wvalid_o / resp_fifo_wready_i / resp_fifo_wdata_o  out/in/out  1/1/RespFifoWidth (32)  response push.
REQ-010 SHALL have xfer_req_o / xfer_ack_i  out/in  1/1  transfer request to bus engine; xfer_dev_idx_o 5, xfer_rnw_o 1, xfer_len_o 16 held stable while xfer_req_o is high.
REQ-011 SHALL have eng_tx_valid_o / eng_tx_ready_i / eng_tx_data_o  out/in/out  1/1/32  write data stream to engine.
REQ-012 SHALL have eng_rx_valid_i / eng_rx_ready_o / eng_rx_data_i  in/out/in  1/1/32  read data stream from engine.
REQ-013 SHALL have xfer_done_i / xfer_err_i / xfer_bytes_i  input  1/4/16  completion pulse, error code, bytes actually moved.
REQ-014 SHALL have busy_o  output  1  high in every state except IDLE.

Function
REQ-015 All handshakes: transfer occurs on a cycle with valid && ready; valid, once high, SHALL not drop nor data change until the transfer.
REQ-016 Command decode: CMD_ATTR [2:0], TID [6:3], DEV_INDEX [20:16], RnW [29], DATA_LENGTH [63:48] bytes.
REQ-017 FSM states: IDLE, DECODE, REQ, XFER, WAIT_DONE, DRAIN, RESP.
REQ-018 IDLE: cmd_fifo_rready_o = enable_i; on pop, latch command -> DECODE.
REQ-019 DECODE: CMD_ATTR != 0 -> RESP with ERR_STATUS 0x5 (unsupported), length 0; else DWORD count = (DATA_LENGTH+3)>>2 computed in 17 bits, stored 15 bits -> REQ.
REQ-020 REQ: xfer_req_o high until xfer_ack_i; then XFER if count != 0, else WAIT_DONE.
REQ-021 XFER write: tx_fifo_rready_o = eng_tx_ready_i, eng_tx_valid_o = tx_fifo_rvalid_i, data passthrough (combinational, zero latency); count decrements per transfer.
REQ-022 XFER read: rx_fifo_wvalid_o = eng_rx_valid_i, eng_rx_ready_o = rx_fifo_wready_i, data passthrough; count decrements per transfer.
REQ-023 Count reaching 0 -> WAIT_DONE; xfer_done_i during XFER SHALL be latched and -> DRAIN (write, DrainOnError=1, count != 0) else RESP.
REQ-024 WAIT_DONE: on xfer_done_i latch xfer_err_i, xfer_bytes_i -> RESP.
REQ-025 DRAIN: tx_fifo_rready_o high, each popped DWORD discarded, count decrements; count 0 -> RESP.
REQ-026 RESP: resp_fifo_wdata_o = {ERR_STATUS[31:28], TID[27:24], 8'h0, DATA_LENGTH[15:0]}; DATA_LENGTH = latched xfer_bytes_i; on handshake -> IDLE.
REQ-027 Engine stream signals SHALL be 0 outside XFER; only one FIFO pop/push path active per state.
REQ-028 Any of cmdrst_i/txrst_i/rxrst_i/resprst_i high: FSM -> IDLE next cycle, all valid/ready outputs 0 while high, in-flight command dropped with no response.
REQ-029 enable_i falling mid-command SHALL not abort it; the current command completes through RESP.
REQ-030 xfer_done_i outside REQ/XFER/WAIT_DONE SHALL be ignored.

Reset
REQ-031 On rst_ni low: state IDLE, count 0, latched command/error/bytes 0, every output 0.
REQ-032 First command pop no earlier than first clock edge after rst_ni release.

Structure
REQ-033 Field offsets, state enum, ERR_STATUS codes (0x0 success, 0x5 unsupported) SHALL live in hci_pkg; widths from hci_pkg.
REQ-034 Single module; no sub-modules.

Verification
REQ-035 Write, len 9, attr 0, TID 3: 3 TX DWORDs forwarded to engine, done err 0 bytes 9 -> response 0x0300_0009.
REQ-036 Read, len 4, TID 7: 1 RX DWORD 0xDEADBEEF pushed to RX FIFO, done -> response 0x0700_0004.
REQ-037 attr 1, TID 2: no xfer_req_o, response 0x5200_0000 within 3 cycles of pop.
REQ-038 Write len 16, engine done with err 0x2 after 1 DWORD: 3 DWORDs drained, response 0x2x00_0004.
REQ-039 txrst_i pulsed during XFER: outputs 0, IDLE next cycle, no response pushed, next command runs normally.
REQ-040 resp_fifo_wready_i held low 10 cycles: response valid and data stable, busy_o high throughout.

Source files
------------

// File: rtl/hci_pkg.sv
// ---------------------------------------------------------------------------
// hci_pkg
// Shared definitions for the PIO command executor: FIFO and field widths,
// command field offsets, FSM state encoding, response error codes and a
// helper that converts a byte length into a DWORD count.
// No ports (package).
// ---------------------------------------------------------------------------
package hci_pkg;

    // FIFO data widths
    localparam int CmdFifoWidth  = 64;
    localparam int TxFifoWidth   = 32;
    localparam int RxFifoWidth   = 32;
    localparam int RespFifoWidth = 32;

    // Field and counter widths
    localparam int DevIdxWidth = 5;
    localparam int LenWidth    = 16;
    localparam int ErrWidth    = 4;
    localparam int TidWidth    = 4;
    localparam int CountWidth  = 15;

    // Command word field offsets
    localparam int CmdAttrLsb = 0;
    localparam int CmdAttrMsb = 2;
    localparam int TidLsb     = 3;
    localparam int TidMsb     = 6;
    localparam int DevIdxLsb  = 16;
    localparam int DevIdxMsb  = 20;
    localparam int RnwBit     = 29;
    localparam int DataLenLsb = 48;
    localparam int DataLenMsb = 63;

    // Response error status codes
    localparam logic [ErrWidth-1:0] ErrSuccess     = 4'h0;
    localparam logic [ErrWidth-1:0] ErrUnsupported = 4'h5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_REQ       = 3'd2,
        ST_XFER      = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_DRAIN     = 3'd5,
        ST_RESP      = 3'd6
    } state_e;

    // Round the byte length up to whole DWORDs; the sum needs 17 bits so a
    // length of 0xFFFF does not wrap, and the result always fits 15 bits.
    function automatic logic [CountWidth-1:0] dword_count(input logic [LenWidth-1:0] len);
        logic [LenWidth:0] w_sum;
        w_sum = {1'b0, len} + 17'd3;
        return w_sum[LenWidth:2];
    endfunction

endpackage

// File: rtl/pio_cmd_exec.sv
// ---------------------------------------------------------------------------
// pio_cmd_exec
// Pops PIO commands from the command FIFO, requests a transfer from the bus
// engine, streams write data TX FIFO -> engine or read data engine -> RX FIFO,
// waits for completion and pushes a response word.
//
// Handshake rule for every valid/ready pair: a beat moves on a cycle where
// valid && ready; a valid, once raised, stays high with stable data until
// that beat.
//
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   enable_i                      fetch new commands only while high
//   cmdrst_i/txrst_i/rxrst_i/resprst_i  soft resets: abort to IDLE
//   cmd_fifo_*                    command pop (64b)
//   tx_fifo_*                     TX data pop (32b)
//   rx_fifo_*                     RX data push (32b)
//   resp_fifo_*                   response push (32b)
//   xfer_req_o/xfer_ack_i + dev_idx/rnw/len   transfer request to engine
//   eng_tx_*, eng_rx_*            data streams to/from engine
//   xfer_done_i/err_i/bytes_i     engine completion
//   busy_o                        high outside IDLE
//   dbg_state_o                   current FSM state for observation
// ---------------------------------------------------------------------------
module pio_cmd_exec
    import hci_pkg::*;
#(
    parameter bit DrainOnError = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic                     cmdrst_i,
    input  logic                     txrst_i,
    input  logic                     rxrst_i,
    input  logic                     resprst_i,
    input  logic                     cmd_fifo_rvalid_i,
    output logic                     cmd_fifo_rready_o,
    input  logic [CmdFifoWidth-1:0]  cmd_fifo_rdata_i,
    input  logic                     tx_fifo_rvalid_i,
    output logic                     tx_fifo_rready_o,
    input  logic [TxFifoWidth-1:0]   tx_fifo_rdata_i,
    output logic                     rx_fifo_wvalid_o,
    input  logic                     rx_fifo_wready_i,
    output logic [RxFifoWidth-1:0]   rx_fifo_wdata_o,
    output logic                     resp_fifo_wvalid_o,
    input  logic                     resp_fifo_wready_i,
    output logic [RespFifoWidth-1:0] resp_fifo_wdata_o,
    output logic                     xfer_req_o,
    input  logic                     xfer_ack_i,
    output logic [DevIdxWidth-1:0]   xfer_dev_idx_o,
    output logic                     xfer_rnw_o,
    output logic [LenWidth-1:0]      xfer_len_o,
    output logic                     eng_tx_valid_o,
    input  logic                     eng_tx_ready_i,
    output logic [31:0]              eng_tx_data_o,
    input  logic                     eng_rx_valid_i,
    output logic                     eng_rx_ready_o,
    input  logic [31:0]              eng_rx_data_i,
    input  logic                     xfer_done_i,
    input  logic [ErrWidth-1:0]      xfer_err_i,
    input  logic [LenWidth-1:0]      xfer_bytes_i,
    output logic                     busy_o,
    output logic [2:0]               dbg_state_o
);

    state_e                  r_state;
    state_e                  w_next_state;
    logic [CmdFifoWidth-1:0] r_cmd;
    logic [CountWidth-1:0]   r_count;
    logic [CountWidth-1:0]   w_count_next;
    logic [ErrWidth-1:0]     r_err;
    logic [LenWidth-1:0]     r_bytes;

    logic                    w_soft_rst;
    logic                    w_active;
    logic [2:0]              w_attr;
    logic [TidWidth-1:0]     w_tid;
    logic                    w_rnw;
    logic [LenWidth-1:0]     w_len;
    logic                    w_cmd_pop;
    logic                    w_tx_pop;
    logic                    w_rx_push;
    logic                    w_resp_push;
    logic                    w_count_dec;
    logic                    w_done_take;
    logic                    w_drain_after_err;
    logic                    w_unused_cmd_bits;

    assign w_soft_rst = cmdrst_i | txrst_i | rxrst_i | resprst_i;
    // Gating with rst_ni keeps every output at 0 while reset is asserted,
    // including cmd_fifo_rready_o which otherwise follows enable_i in IDLE.
    assign w_active   = rst_ni & ~w_soft_rst;

    assign w_attr = r_cmd[CmdAttrMsb:CmdAttrLsb];
    assign w_tid  = r_cmd[TidMsb:TidLsb];
    assign w_rnw  = r_cmd[RnwBit];
    assign w_len  = r_cmd[DataLenMsb:DataLenLsb];
    assign w_unused_cmd_bits = ^{r_cmd[15:7], r_cmd[28:21], r_cmd[47:30]};

    assign w_cmd_pop   = cmd_fifo_rvalid_i & cmd_fifo_rready_o;
    assign w_tx_pop    = tx_fifo_rvalid_i & tx_fifo_rready_o;
    assign w_rx_push   = rx_fifo_wvalid_o & rx_fifo_wready_i;
    assign w_resp_push = resp_fifo_wvalid_o & resp_fifo_wready_i;

    // Only one pop/push path is open per state, so the count can simply
    // decrement on whichever data beat the current state allows.
    assign w_count_dec  = ((r_state == ST_XFER) && (w_rnw ? w_rx_push : w_tx_pop)) ||
                          ((r_state == ST_DRAIN) && w_tx_pop);
    assign w_count_next = r_count - {{(CountWidth-1){1'b0}}, w_count_dec};

    // Completion is honoured only while a transfer is actually outstanding.
    assign w_done_take = xfer_done_i &&
                         (((r_state == ST_REQ) && xfer_ack_i) ||
                          (r_state == ST_XFER) || (r_state == ST_WAIT_DONE));

    // A failed write leaves TX DWORDs behind; drain them so the next command
    // starts on a clean TX FIFO.
    assign w_drain_after_err = DrainOnError && !w_rnw && (w_count_next != '0);

    assign xfer_dev_idx_o = r_cmd[DevIdxMsb:DevIdxLsb];
    assign xfer_rnw_o     = w_rnw;
    assign xfer_len_o     = w_len;
    assign busy_o         = (r_state != ST_IDLE);
    assign dbg_state_o    = r_state;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_pop) w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                w_next_state = (w_attr != 3'd0) ? ST_RESP : ST_REQ;
            end
            ST_REQ: begin
                if (xfer_ack_i) begin
                    if (xfer_done_i)
                        w_next_state = w_drain_after_err ? ST_DRAIN : ST_RESP;
                    else
                        w_next_state = (r_count != '0) ? ST_XFER : ST_WAIT_DONE;
                end
            end
            ST_XFER: begin
                if (xfer_done_i)
                    w_next_state = w_drain_after_err ? ST_DRAIN : ST_RESP;
                else if (w_count_next == '0)
                    w_next_state = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (xfer_done_i) w_next_state = ST_RESP;
            end
            ST_DRAIN: begin
                if (w_count_next == '0) w_next_state = ST_RESP;
            end
            ST_RESP: begin
                if (w_resp_push) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (w_soft_rst) w_next_state = ST_IDLE;
    end

    // Output logic
    always_comb begin
        cmd_fifo_rready_o  = 1'b0;
        tx_fifo_rready_o   = 1'b0;
        rx_fifo_wvalid_o   = 1'b0;
        rx_fifo_wdata_o    = '0;
        resp_fifo_wvalid_o = 1'b0;
        resp_fifo_wdata_o  = '0;
        xfer_req_o         = 1'b0;
        eng_tx_valid_o     = 1'b0;
        eng_tx_data_o      = '0;
        eng_rx_ready_o     = 1'b0;
        if (w_active) begin
            case (r_state)
                ST_IDLE: cmd_fifo_rready_o = enable_i;
                ST_REQ:  xfer_req_o = 1'b1;
                ST_XFER: begin
                    // Zero-latency passthrough between FIFO and engine.
                    if (w_rnw) begin
                        rx_fifo_wvalid_o = eng_rx_valid_i;
                        eng_rx_ready_o   = rx_fifo_wready_i;
                        rx_fifo_wdata_o  = eng_rx_data_i;
                    end else begin
                        eng_tx_valid_o   = tx_fifo_rvalid_i;
                        tx_fifo_rready_o = eng_tx_ready_i;
                        eng_tx_data_o    = tx_fifo_rdata_i;
                    end
                end
                ST_DRAIN: tx_fifo_rready_o = 1'b1;
                ST_RESP: begin
                    resp_fifo_wvalid_o = 1'b1;
                    resp_fifo_wdata_o  = {r_err, w_tid, 8'h00, r_bytes};
                end
                default: ;
            endcase
        end
    end

    // Command, count and completion registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cmd   <= '0;
            r_count <= '0;
            r_err   <= '0;
            r_bytes <= '0;
        end else if (w_soft_rst) begin
            r_count <= '0;
            r_err   <= '0;
            r_bytes <= '0;
        end else begin
            if (w_cmd_pop) r_cmd <= cmd_fifo_rdata_i;
            if (r_state == ST_DECODE) begin
                r_bytes <= '0;
                if (w_attr != 3'd0) begin
                    r_err   <= ErrUnsupported;
                    r_count <= '0;
                end else begin
                    r_err   <= ErrSuccess;
                    r_count <= dword_count(w_len);
                end
            end else begin
                if (w_count_dec) r_count <= w_count_next;
                if (w_done_take) begin
                    r_err   <= xfer_err_i;
                    r_bytes <= xfer_bytes_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_pio_cmd_exec.sv
module tb_pio_cmd_exec;
    import hci_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        enable_i = 1'b1;
    logic        cmdrst_i = 1'b0, txrst_i = 1'b0, rxrst_i = 1'b0, resprst_i = 1'b0;
    logic        cmd_fifo_rvalid_i = 1'b0;
    logic        cmd_fifo_rready_o;
    logic [63:0] cmd_fifo_rdata_i = '0;
    logic        tx_fifo_rvalid_i = 1'b0;
    logic        tx_fifo_rready_o;
    logic [31:0] tx_fifo_rdata_i = '0;
    logic        rx_fifo_wvalid_o;
    logic        rx_fifo_wready_i = 1'b1;
    logic [31:0] rx_fifo_wdata_o;
    logic        resp_fifo_wvalid_o;
    logic        resp_fifo_wready_i = 1'b1;
    logic [31:0] resp_fifo_wdata_o;
    logic        xfer_req_o;
    logic        xfer_ack_i = 1'b0;
    logic [4:0]  xfer_dev_idx_o;
    logic        xfer_rnw_o;
    logic [15:0] xfer_len_o;
    logic        eng_tx_valid_o;
    logic        eng_tx_ready_i = 1'b1;
    logic [31:0] eng_tx_data_o;
    logic        eng_rx_valid_i = 1'b0;
    logic        eng_rx_ready_o;
    logic [31:0] eng_rx_data_i = '0;
    logic        xfer_done_i = 1'b0;
    logic [3:0]  xfer_err_i = '0;
    logic [15:0] xfer_bytes_i = '0;
    logic        busy_o;
    logic [2:0]  dbg_state_o;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] resp_q[$];
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];

    pio_cmd_exec #(.DrainOnError(1'b1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i),
        .cmdrst_i(cmdrst_i), .txrst_i(txrst_i), .rxrst_i(rxrst_i), .resprst_i(resprst_i),
        .cmd_fifo_rvalid_i(cmd_fifo_rvalid_i), .cmd_fifo_rready_o(cmd_fifo_rready_o),
        .cmd_fifo_rdata_i(cmd_fifo_rdata_i),
        .tx_fifo_rvalid_i(tx_fifo_rvalid_i), .tx_fifo_rready_o(tx_fifo_rready_o),
        .tx_fifo_rdata_i(tx_fifo_rdata_i),
        .rx_fifo_wvalid_o(rx_fifo_wvalid_o), .rx_fifo_wready_i(rx_fifo_wready_i),
        .rx_fifo_wdata_o(rx_fifo_wdata_o),
        .resp_fifo_wvalid_o(resp_fifo_wvalid_o), .resp_fifo_wready_i(resp_fifo_wready_i),
        .resp_fifo_wdata_o(resp_fifo_wdata_o),
        .xfer_req_o(xfer_req_o), .xfer_ack_i(xfer_ack_i),
        .xfer_dev_idx_o(xfer_dev_idx_o), .xfer_rnw_o(xfer_rnw_o), .xfer_len_o(xfer_len_o),
        .eng_tx_valid_o(eng_tx_valid_o), .eng_tx_ready_i(eng_tx_ready_i),
        .eng_tx_data_o(eng_tx_data_o),
        .eng_rx_valid_i(eng_rx_valid_i), .eng_rx_ready_o(eng_rx_ready_o),
        .eng_rx_data_i(eng_rx_data_i),
        .xfer_done_i(xfer_done_i), .xfer_err_i(xfer_err_i), .xfer_bytes_i(xfer_bytes_i),
        .busy_o(busy_o), .dbg_state_o(dbg_state_o)
    );

    // Clock / reset
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every handshake on an output path against the
    // expected queues; a beat with nothing expected is itself a failure.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (resp_fifo_wvalid_o && resp_fifo_wready_i) begin
                if (resp_q.size() == 0) check("resp_unexpected", {32'h0, resp_fifo_wdata_o}, 64'hffff_ffff);
                else check("resp_data", {32'h0, resp_fifo_wdata_o}, {32'h0, resp_q.pop_front()});
            end
            if (eng_tx_valid_o && eng_tx_ready_i) begin
                if (tx_q.size() == 0) check("eng_tx_unexpected", {32'h0, eng_tx_data_o}, 64'hffff_ffff);
                else check("eng_tx_data", {32'h0, eng_tx_data_o}, {32'h0, tx_q.pop_front()});
            end
            if (rx_fifo_wvalid_o && rx_fifo_wready_i) begin
                if (rx_q.size() == 0) check("rx_push_unexpected", {32'h0, rx_fifo_wdata_o}, 64'hffff_ffff);
                else check("rx_push_data", {32'h0, rx_fifo_wdata_o}, {32'h0, rx_q.pop_front()});
            end
        end
    end

    // Driver tasks
    function automatic logic sig(input int sel);
        case (sel)
            0: return cmd_fifo_rready_o;
            1: return xfer_req_o;
            2: return tx_fifo_rready_o;
            3: return eng_rx_ready_o;
            4: return resp_fifo_wvalid_o;
            5: return !busy_o;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input string name);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (sig(sel)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check(name, 64'h0, 64'h1);
    endtask

    task automatic send_cmd(input logic [2:0] attr, input logic [3:0] tid, input logic [4:0] dev,
                            input logic rnw, input logic [15:0] len);
        logic [63:0] d = '0;
        d[2:0]   = attr;
        d[6:3]   = tid;
        d[20:16] = dev;
        d[29]    = rnw;
        d[63:48] = len;
        @(posedge clk_i); #1;
        cmd_fifo_rvalid_i = 1'b1;
        cmd_fifo_rdata_i  = d;
        wait_sig(0, "timeout_cmd_pop");
        @(posedge clk_i); #1;
        cmd_fifo_rvalid_i = 1'b0;
    endtask

    task automatic do_ack(input logic [4:0] dev, input logic rnw, input logic [15:0] len);
        wait_sig(1, "timeout_xfer_req");
        check("xfer_fields", {40'h0, xfer_dev_idx_o, xfer_rnw_o, xfer_len_o}, {40'h0, dev, rnw, len});
        @(posedge clk_i); #1;
        xfer_ack_i = 1'b1;
        @(posedge clk_i); #1;
        xfer_ack_i = 1'b0;
    endtask

    task automatic push_tx(input logic [31:0] d);
        tx_fifo_rvalid_i = 1'b1;
        tx_fifo_rdata_i  = d;
        wait_sig(2, "timeout_tx_pop");
        @(posedge clk_i); #1;
        tx_fifo_rvalid_i = 1'b0;
    endtask

    task automatic push_rx(input logic [31:0] d);
        eng_rx_valid_i = 1'b1;
        eng_rx_data_i  = d;
        wait_sig(3, "timeout_eng_rx");
        @(posedge clk_i); #1;
        eng_rx_valid_i = 1'b0;
    endtask

    task automatic pulse_done(input logic [3:0] err, input logic [15:0] bytes);
        @(posedge clk_i); #1;
        xfer_done_i  = 1'b1;
        xfer_err_i   = err;
        xfer_bytes_i = bytes;
        @(posedge clk_i); #1;
        xfer_done_i  = 1'b0;
        xfer_err_i   = '0;
        xfer_bytes_i = '0;
    endtask

    // Stimulus
    initial begin
        bit seen;
        // Reset state
        #2;
        check("rst_cmd_rready", {63'h0, cmd_fifo_rready_o}, 64'h0);
        check("rst_outputs", {56'h0, busy_o, xfer_req_o, tx_fifo_rready_o, rx_fifo_wvalid_o,
                              resp_fifo_wvalid_o, eng_tx_valid_o, eng_rx_ready_o, 1'b0}, 64'h0);
        check("rst_state", {61'h0, dbg_state_o}, 64'h0);
        #21 rst_ni = 1'b1;

        // Write, len 9, TID 3: three DWORDs forwarded
        tx_q.push_back(32'h1111_0001);
        tx_q.push_back(32'h2222_0002);
        tx_q.push_back(32'h3333_0003);
        resp_q.push_back(32'h0300_0009);
        send_cmd(3'd0, 4'd3, 5'd4, 1'b0, 16'd9);
        do_ack(5'd4, 1'b0, 16'd9);
        push_tx(32'h1111_0001);
        push_tx(32'h2222_0002);
        push_tx(32'h3333_0003);
        pulse_done(4'h0, 16'd9);
        wait_sig(5, "timeout_idle_wr");

        // Read, len 4, TID 7; enable dropped mid-command must not abort
        rx_q.push_back(32'hDEAD_BEEF);
        resp_q.push_back(32'h0700_0004);
        send_cmd(3'd0, 4'd7, 5'd9, 1'b1, 16'd4);
        enable_i = 1'b0;
        do_ack(5'd9, 1'b1, 16'd4);
        push_rx(32'hDEAD_BEEF);
        pulse_done(4'h0, 16'd4);
        wait_sig(5, "timeout_idle_rd");
        check("rready_when_disabled", {63'h0, cmd_fifo_rready_o}, 64'h0);
        enable_i = 1'b1;

        // Unsupported attr 1, TID 2: no request, response within 3 cycles
        resp_q.push_back(32'h5200_0000);
        send_cmd(3'd1, 4'd2, 5'd1, 1'b0, 16'd8);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("unsup_no_req", {63'h0, xfer_req_o}, 64'h0);
            if (resp_fifo_wvalid_o) seen = 1;
        end
        check("unsup_resp_latency", {63'h0, seen}, 64'h1);
        wait_sig(5, "timeout_idle_unsup");

        // Write len 16, error after one DWORD: three DWORDs drained
        tx_q.push_back(32'hA5A5_0000);
        resp_q.push_back(32'h2500_0004);
        send_cmd(3'd0, 4'd5, 5'd2, 1'b0, 16'd16);
        do_ack(5'd2, 1'b0, 16'd16);
        push_tx(32'hA5A5_0000);
        pulse_done(4'h2, 16'd4);
        check("drain_state", {61'h0, dbg_state_o}, {61'h0, ST_DRAIN});
        push_tx(32'hBAD0_0001);
        push_tx(32'hBAD0_0002);
        push_tx(32'hBAD0_0003);
        wait_sig(5, "timeout_idle_drain");

        // txrst during XFER: outputs 0 while high, IDLE next, no response
        send_cmd(3'd0, 4'd1, 5'd3, 1'b0, 16'd8);
        do_ack(5'd3, 1'b0, 16'd8);
        tx_fifo_rvalid_i = 1'b1;
        tx_fifo_rdata_i  = 32'hCAFE_0000;
        txrst_i = 1'b1;
        @(negedge clk_i);
        check("softrst_outputs", {57'h0, cmd_fifo_rready_o, xfer_req_o, tx_fifo_rready_o,
                                  rx_fifo_wvalid_o, resp_fifo_wvalid_o, eng_tx_valid_o,
                                  eng_rx_ready_o}, 64'h0);
        @(posedge clk_i); #1;
        txrst_i = 1'b0;
        tx_fifo_rvalid_i = 1'b0;
        @(negedge clk_i);
        check("softrst_idle", {60'h0, busy_o, dbg_state_o}, 64'h0);

        // Response backpressure for 10 cycles; also the command after txrst
        resp_fifo_wready_i = 1'b0;
        tx_q.push_back(32'h0909_0909);
        resp_q.push_back(32'h0900_0004);
        send_cmd(3'd0, 4'd9, 5'd7, 1'b0, 16'd4);
        do_ack(5'd7, 1'b0, 16'd4);
        push_tx(32'h0909_0909);
        pulse_done(4'h0, 16'd4);
        wait_sig(4, "timeout_resp_valid");
        for (int i = 0; i < 10; i++) begin
            check("stall_resp", {31'h0, busy_o, resp_fifo_wvalid_o, resp_fifo_wdata_o},
                  {31'h0, 1'b1, 1'b1, 32'h0900_0004});
            @(negedge clk_i);
        end
        @(posedge clk_i); #1;
        resp_fifo_wready_i = 1'b1;
        wait_sig(5, "timeout_idle_stall");

        // Zero-length write: straight to WAIT_DONE
        resp_q.push_back(32'h0400_0000);
        send_cmd(3'd0, 4'd4, 5'd0, 1'b0, 16'd0);
        do_ack(5'd0, 1'b0, 16'd0);
        @(negedge clk_i);
        check("len0_wait_done", {61'h0, dbg_state_o}, {61'h0, ST_WAIT_DONE});
        pulse_done(4'h0, 16'd0);
        wait_sig(5, "timeout_idle_len0");

        repeat (3) @(negedge clk_i);
        check("resp_q_empty", 64'(resp_q.size()), 64'h0);
        check("tx_q_empty", 64'(tx_q.size()), 64'h0);
        check("rx_q_empty", 64'(rx_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
